sdram_arbiter: RTL

- Owns the single SDRAM command/address bus after power-up.
- Muxes four requesters onto it: the initialization sequencer, the auto-refresh engine, the write engine and the read engine.
- Generates the periodic refresh request internally, gives refresh absolute priority, and round-robins writes and reads.
- Sits between the init/refresh/write/read engines and the SDRAM pins, one level below the user-facing controller top.

---
 rtl/sdram_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/sdram_arbiter.sv
// SDRAM command/address bus arbiter.
// After the init sequencer finishes, the arbiter hands the single SDRAM bus
// to the refresh, write or read engine, one at a time. Refresh has absolute
// priority. Writes and reads alternate when both are pending. A periodic
// refresh request is generated internally from a free-running interval counter.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_INIT | init sequencer drives the bus, waiting for init_end
// S_ARB  | bus idle (NOP), choose the next owner
// S_AREF | refresh engine owns the bus until aref_end
// S_WR   | write engine owns the bus until wr_end
// S_RD   | read engine owns the bus until rd_end
module sdram_arbiter #(
  parameter int CLK       = 100_000_000,
  parameter int TREFI     = 7800,
  parameter int REF_CNT_W = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_end,
  input  logic [3:0]  init_cmd,
  input  logic [1:0]  init_ba,
  input  logic [12:0] init_addr,
  input  logic [3:0]  aref_cmd,
  input  logic [1:0]  aref_ba,
  input  logic [12:0] aref_addr,
  input  logic        aref_end,
  input  logic        wr_req,
  input  logic [3:0]  wr_cmd,
  input  logic [1:0]  wr_ba,
  input  logic [12:0] wr_addr,
  input  logic        wr_end,
  input  logic        rd_req,
  input  logic [3:0]  rd_cmd,
  input  logic [1:0]  rd_ba,
  input  logic [12:0] rd_addr,
  input  logic        rd_end,
  output logic        aref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic        aref_pending,
  output logic [3:0]  sdram_cmd,
  output logic [1:0]  sdram_ba,
  output logic [12:0] sdram_addr
);

  localparam int CLK_NS     = 1_000_000_000 / CLK;
  localparam int REF_CYCLES = TREFI / CLK_NS;
  localparam logic [REF_CNT_W-1:0] REF_LAST = REF_CNT_W'(REF_CYCLES - 1);

  // NOP is CS# low with RAS#, CAS#, WE# high; idle bus parks ba/addr high.
  localparam logic [3:0]  OP_NOP    = 4'b0111;
  localparam logic [1:0]  IDLE_BA   = 2'b11;
  localparam logic [12:0] IDLE_ADDR = 13'h1fff;

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_ARB  = 3'd1,
    S_AREF = 3'd2,
    S_WR   = 3'd3,
    S_RD   = 3'd4
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  last_wr;
  logic [REF_CNT_W-1:0]  ref_cnt;
  logic                  ref_wrap;

  // The interval counter only advances once init is done; wrap marks a due refresh.
  assign ref_wrap = init_end && (ref_cnt == REF_LAST);

  // Refresh interval counter, free-running through bursts so refreshes are delayed, never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt <= '0;
    end else if (!init_end || ref_wrap) begin
      ref_cnt <= '0;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  // Pending flag: set on wrap, cleared on entry to S_AREF; a coincident wrap keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aref_pending <= 1'b0;
    end else if (ref_wrap) begin
      aref_pending <= 1'b1;
    end else if (state == S_ARB && aref_pending) begin
      aref_pending <= 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Round-robin memory: remembers whether the last completed burst was a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_wr <= 1'b0;
    end else if (state == S_WR && wr_end) begin
      last_wr <= 1'b1;
    end else if (state == S_RD && rd_end) begin
      last_wr <= 1'b0;
    end
  end

  // Next-state logic; end pulses only matter in the state that owns them.
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT: begin
        if (init_end) state_nxt = S_ARB;
      end
      S_ARB: begin
        if (aref_pending) begin
          state_nxt = S_AREF;
        end else if (wr_req && rd_req) begin
          state_nxt = last_wr ? S_RD : S_WR;
        end else if (wr_req) begin
          state_nxt = S_WR;
        end else if (rd_req) begin
          state_nxt = S_RD;
        end
      end
      S_AREF: begin
        if (aref_end) state_nxt = S_ARB;
      end
      S_WR: begin
        if (wr_end) state_nxt = S_ARB;
      end
      S_RD: begin
        if (rd_end) state_nxt = S_ARB;
      end
      default: state_nxt = S_ARB;
    endcase
  end

  assign aref_en = (state == S_AREF);
  assign wr_en   = (state == S_WR);
  assign rd_en   = (state == S_RD);

  // Bus mux, selected by state only so requester inputs pass straight through.
  always_comb begin
    sdram_cmd  = OP_NOP;
    sdram_ba   = IDLE_BA;
    sdram_addr = IDLE_ADDR;
    case (state)
      S_INIT: begin
        sdram_cmd  = init_cmd;
        sdram_ba   = init_ba;
        sdram_addr = init_addr;
      end
      S_AREF: begin
        sdram_cmd  = aref_cmd;
        sdram_ba   = aref_ba;
        sdram_addr = aref_addr;
      end
      S_WR: begin
        sdram_cmd  = wr_cmd;
        sdram_ba   = wr_ba;
        sdram_addr = wr_addr;
      end
      S_RD: begin
        sdram_cmd  = rd_cmd;
        sdram_ba   = rd_ba;
        sdram_addr = rd_addr;
      end
      default: begin
        sdram_cmd  = OP_NOP;
        sdram_ba   = IDLE_BA;
        sdram_addr = IDLE_ADDR;
      end
    endcase
  end

endmodule
